// File: rtl/riscv_mmio_pkg.sv
// Shared constants and types for the data-side memory subsystem.
// Holds the MMIO base/offset map, TXSTAT and CYCCTL bit positions and the
// region-select enum used by the address decoder.
package riscv_mmio_pkg;

    localparam logic [31:0] MMIO_BASE = 32'h8000_0000;

    // Word offsets inside the MMIO window (address bits [7:0], bits [1:0] zero).
    localparam logic [7:0] OFF_GPIO   = 8'h00;
    localparam logic [7:0] OFF_TXDATA = 8'h04;
    localparam logic [7:0] OFF_TXSTAT = 8'h08;
    localparam logic [7:0] OFF_CYCCTL = 8'h0C;
    localparam logic [7:0] OFF_CYCLO  = 8'h10;
    localparam logic [7:0] OFF_CYCHI  = 8'h14;

    // TXSTAT layout: {overflow[31], full[9], empty[8], count[7:0]}.
    localparam int TXSTAT_OVF_BIT   = 31;
    localparam int TXSTAT_FULL_BIT  = 9;
    localparam int TXSTAT_EMPTY_BIT = 8;

    // CYCCTL write bits.
    localparam int CYCCTL_SNAP_BIT = 0;
    localparam int CYCCTL_CLR_BIT  = 1;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_MMIO,
        REG_NONE
    } region_e;

endpackage

// File: rtl/mmio_tx_fifo.sv
// Transmit FIFO for the MMIO TXDATA register.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   push, push_data   - enqueue request and byte
//   clr_ovf           - clears the sticky overflow flag
//   tx_data, tx_valid - head entry and non-empty flag (egress)
//   tx_ready          - consumer takes the head this cycle
//   count, full, empty, overflow - status for TXSTAT
// Egress handshake: a byte transfers on every posedge where tx_valid && tx_ready
// are both high; tx_data is held stable while tx_valid is high and tx_ready is low.
module mmio_tx_fifo #(
    parameter int TX_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic [7:0]                  push_data,
    input  logic                        clr_ovf,
    input  logic                        tx_ready,
    output logic [7:0]                  tx_data,
    output logic                        tx_valid,
    output logic [$clog2(TX_DEPTH):0]   count,
    output logic                        full,
    output logic                        empty,
    output logic                        overflow
);

    localparam int PW = $clog2(TX_DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    mem [TX_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          pop;
    logic          push_ok;

    assign empty    = (count == '0);
    assign full     = (count == CW'(TX_DEPTH));
    assign tx_valid = !empty;
    assign tx_data  = mem[rd_ptr];
    assign pop      = tx_valid && tx_ready;
    // When full, a simultaneous pop frees the slot the write lands in
    // (wr_ptr == rd_ptr), so the push can still be taken.
    assign push_ok  = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < TX_DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push_ok && !pop) begin
                count <= count + CW'(1);
            end else if (!push_ok && pop) begin
                count <= count - CW'(1);
            end
            // A rejected push outranks a same-cycle clear.
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/dmem_mmio_subsystem.sv
// Data memory subsystem behind the core's M stage: word RAM plus an MMIO
// window (GPIO, transmit FIFO, 64-bit cycle counter with snapshot).
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   dmem_write                 - store strobe
//   alu_result_m               - byte address (bits [1:0] ignored)
//   dmem_write_data            - store data
//   dmem_read_data             - combinational load data
//   tx_data, tx_valid, tx_ready - transmit FIFO egress
//   gpio_out                   - GPIO output register
// Build option: define CYCLE_COUNTER_EN to include the cycle counter and
// snapshot; without it CYCLO/CYCHI read 0 and CYCCTL writes are ignored.
module dmem_mmio_subsystem
    import riscv_mmio_pkg::*;
#(
    parameter int RAM_WORDS = 1024,
    parameter int TX_DEPTH  = 8,
    parameter int GPIO_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dmem_write,
    input  logic [31:0]       alu_result_m,
    input  logic [31:0]       dmem_write_data,
    output logic [31:0]       dmem_read_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [GPIO_W-1:0] gpio_out
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int CW = $clog2(TX_DEPTH) + 1;

    region_e       region;
    logic [AW-1:0] ram_idx;
    logic [7:0]    mmio_off;
    logic [31:0]   ram [RAM_WORDS];
    logic          mmio_wr;
    logic          gpio_we;
    logic          tx_push;
    logic          ovf_clr;
    logic [CW-1:0] tx_count;
    logic          tx_full;
    logic          tx_empty;
    logic          tx_overflow;
    logic [31:0]   txstat;
    logic [31:0]   snap_lo;
    logic [31:0]   snap_hi;
    logic          unused_addr_bits;

    assign unused_addr_bits = &{1'b0, alu_result_m[1:0]};

    assign ram_idx  = alu_result_m[AW+1:2];
    assign mmio_off = {alu_result_m[7:2], 2'b00};

    always_comb begin
        if (alu_result_m[31:AW+2] == '0) begin
            region = REG_RAM;
        end else if (alu_result_m[31:8] == MMIO_BASE[31:8]) begin
            region = REG_MMIO;
        end else begin
            region = REG_NONE;
        end
    end

    assign mmio_wr = dmem_write && (region == REG_MMIO);
    assign gpio_we = mmio_wr && (mmio_off == OFF_GPIO);
    assign tx_push = mmio_wr && (mmio_off == OFF_TXDATA);
    assign ovf_clr = mmio_wr && (mmio_off == OFF_TXSTAT);

    // RAM is deliberately not reset; reads see the pre-write value this cycle.
    always_ff @(posedge clk) begin
        if (dmem_write && (region == REG_RAM)) begin
            ram[ram_idx] <= dmem_write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gpio_out <= '0;
        end else if (gpio_we) begin
            gpio_out <= dmem_write_data[GPIO_W-1:0];
        end
    end

    mmio_tx_fifo #(
        .TX_DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (tx_push),
        .push_data (dmem_write_data[7:0]),
        .clr_ovf   (ovf_clr),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .count     (tx_count),
        .full      (tx_full),
        .empty     (tx_empty),
        .overflow  (tx_overflow)
    );

`ifdef CYCLE_COUNTER_EN
    logic        cyc_we;
    logic [63:0] cyc_cnt;
    logic [63:0] cyc_snap;

    assign cyc_we = mmio_wr && (mmio_off == OFF_CYCCTL);

    // Snapshot takes the value before this cycle's increment/clear, so
    // snapshot+clear in one write captures the old count.
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_cnt  <= '0;
            cyc_snap <= '0;
        end else begin
            if (cyc_we && dmem_write_data[CYCCTL_SNAP_BIT]) begin
                cyc_snap <= cyc_cnt;
            end
            if (cyc_we && dmem_write_data[CYCCTL_CLR_BIT]) begin
                cyc_cnt <= '0;
            end else begin
                cyc_cnt <= cyc_cnt + 64'd1;
            end
        end
    end

    assign snap_lo = cyc_snap[31:0];
    assign snap_hi = cyc_snap[63:32];
`else
    assign snap_lo = '0;
    assign snap_hi = '0;
`endif

    always_comb begin
        txstat                    = '0;
        txstat[TXSTAT_OVF_BIT]    = tx_overflow;
        txstat[TXSTAT_FULL_BIT]   = tx_full;
        txstat[TXSTAT_EMPTY_BIT]  = tx_empty;
        txstat[7:0]               = 8'(tx_count);
    end

    always_comb begin
        dmem_read_data = '0;
        case (region)
            REG_RAM: dmem_read_data = ram[ram_idx];
            REG_MMIO: begin
                case (mmio_off)
                    OFF_GPIO:   dmem_read_data = 32'(gpio_out);
                    OFF_TXSTAT: dmem_read_data = txstat;
                    OFF_CYCLO:  dmem_read_data = snap_lo;
                    OFF_CYCHI:  dmem_read_data = snap_hi;
                    default:    dmem_read_data = '0;
                endcase
            end
            default: dmem_read_data = '0;
        endcase
    end

endmodule

// File: tb/tb_dmem_mmio_subsystem.sv
// Testbench for dmem_mmio_subsystem: table of bus vectors, hand-written
// FIFO / reset / counter sequences, and an egress scoreboard queue.
module tb_dmem_mmio_subsystem;

    localparam int RAM_WORDS = 1024;
    localparam int TX_DEPTH  = 8;
    localparam int GPIO_W    = 8;

    localparam logic [31:0] A_GPIO   = 32'h8000_0000;
    localparam logic [31:0] A_TXDATA = 32'h8000_0004;
    localparam logic [31:0] A_TXSTAT = 32'h8000_0008;
    localparam logic [31:0] A_CYCCTL = 32'h8000_000C;
    localparam logic [31:0] A_CYCLO  = 32'h8000_0010;
    localparam logic [31:0] A_CYCHI  = 32'h8000_0014;

    // ---------------- clock / reset ----------------
    logic              clk = 1'b0;
    logic              reset;
    logic              dmem_write;
    logic [31:0]       alu_result_m;
    logic [31:0]       dmem_write_data;
    logic [31:0]       dmem_read_data;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [GPIO_W-1:0] gpio_out;

    always #5 clk = ~clk;

    dmem_mmio_subsystem #(
        .RAM_WORDS (RAM_WORDS),
        .TX_DEPTH  (TX_DEPTH),
        .GPIO_W    (GPIO_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .dmem_write      (dmem_write),
        .alu_result_m    (alu_result_m),
        .dmem_write_data (dmem_write_data),
        .dmem_read_data  (dmem_read_data),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .gpio_out        (gpio_out)
    );

    // ---------------- scoreboard state ----------------
    int         pass_cnt   = 0;
    int         total_cnt  = 0;
    logic [7:0] exp_q[$];
    logic       model_ovf  = 1'b0;
    int         live_edges = 0;

    // Non-reset edges since the last reset edge equals the DUT counter value.
    always @(posedge clk) begin
        if (reset) live_edges = 0;
        else       live_edges = live_edges + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Egress monitor: a transfer seen mid-cycle commits at the next posedge.
    always @(negedge clk) begin
        if (!reset && tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL tx_unexpected: got 0x%02h expected no transfer", tx_data);
            end else begin
                check("tx_egress", 32'(tx_data), 32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        if (addr == A_TXDATA) begin
            if (exp_q.size() < TX_DEPTH || (exp_q.size() > 0 && tx_ready)) exp_q.push_back(data[7:0]);
            else model_ovf = 1'b1;
        end else if (addr == A_TXSTAT) begin
            model_ovf = 1'b0;
        end
        dmem_write      = 1'b1;
        alu_result_m    = addr;
        dmem_write_data = data;
        step();
        dmem_write      = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        dmem_write   = 1'b0;
        alu_result_m = addr;
        @(negedge clk);
        data = dmem_read_data;
        step();
    endtask

    task automatic read_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        bus_read(addr, rd);
        check(name, rd, exp);
    endtask

    task automatic drain(input string name);
        int n = 0;
        tx_ready = 1'b1;
        while (exp_q.size() != 0 && n < 64) begin
            step();
            n++;
        end
        if (exp_q.size() != 0) begin
            total_cnt++;
            $display("FAIL %s_timeout: got %0d bytes left expected 0", name, exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        check({name, "_valid_low"}, 32'(tx_valid), 32'h0);
        step();
        tx_ready = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;

    function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp, input string name);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.exp = exp; v.name = name;
        return v;
    endfunction

    vec_t vecs[12];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          snap_exp;
        int          l_clr;

        vecs[0]  = mk(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "ram_store_load");
        vecs[1]  = mk(1'b0, 32'h4000_0000, 32'h0,         32'h0,         "unmapped_read");
        vecs[2]  = mk(1'b1, A_GPIO,        32'h0000_01A5, 32'h0000_00A5, "gpio_rw");
        vecs[3]  = mk(1'b1, 32'h4000_0000, 32'h0000_1234, 32'h0,         "unmapped_write");
        vecs[4]  = mk(1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 32'hCAFE_F00D, "ram_last_word");
        vecs[5]  = mk(1'b0, 32'h0000_1000, 32'h0,         32'h0,         "ram_past_end");
        vecs[6]  = mk(1'b1, 32'h0000_0041, 32'h1111_2222, 32'h1111_2222, "ram_unaligned_wr");
        vecs[7]  = mk(1'b0, 32'h0000_0043, 32'h0,         32'h1111_2222, "ram_byte_bits_ignored");
        vecs[8]  = mk(1'b0, A_TXDATA,      32'h0,         32'h0,         "txdata_reads_zero");
        vecs[9]  = mk(1'b1, A_CYCCTL,      32'h0,         32'h0,         "cycctl_reads_zero");
        vecs[10] = mk(1'b1, 32'h8000_0018, 32'hFFFF_FFFF, 32'h0,         "mmio_hole");
        vecs[11] = mk(1'b1, 32'h8000_0100, 32'h0000_0077, 32'h0,         "mmio_outside_window");

        reset = 1'b1; dmem_write = 1'b0; alu_result_m = '0; dmem_write_data = '0; tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_tx_valid", 32'(tx_valid), 32'h0);
        check("rst_tx_data", 32'(tx_data), 32'h0);
        check("rst_gpio", 32'(gpio_out), 32'h0);
        step();
        read_check("rst_txstat", A_TXSTAT, 32'h0000_0100);
        read_check("rst_cyclo", A_CYCLO, 32'h0);

        // Table-driven bus accesses
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata);
            read_check(vecs[i].name, vecs[i].addr, vecs[i].exp);
        end
        @(negedge clk);
        check("gpio_out_pin", 32'(gpio_out), 32'h0000_00A5);
        step();

        // Same-cycle RAM read during a write returns the old word
        bus_write(32'h0000_0080, 32'h0000_0001);
        dmem_write = 1'b1; alu_result_m = 32'h0000_0080; dmem_write_data = 32'h0000_0002;
        @(negedge clk);
        check("ram_read_during_write", dmem_read_data, 32'h0000_0001);
        step();
        dmem_write = 1'b0;
        read_check("ram_after_write", 32'h0000_0080, 32'h0000_0002);

        // FIFO fill to full, then overflow
        tx_ready = 1'b0;
        for (int i = 1; i <= 8; i++) bus_write(A_TXDATA, 32'(i));
        read_check("txstat_full", A_TXSTAT, 32'h0000_0208);
        @(negedge clk);
        check("head_byte", 32'(tx_data), 32'h01);
        check("head_valid", 32'(tx_valid), 32'h1);
        step();
        bus_write(A_TXDATA, 32'h09);
        read_check("txstat_overflow", A_TXSTAT, 32'h8000_0208);
        repeat (3) step();
        @(negedge clk);
        check("head_stable_no_ready", 32'(tx_data), 32'h01);
        step();
        bus_write(A_TXSTAT, 32'h0);
        read_check("txstat_ovf_cleared", A_TXSTAT, 32'h0000_0208);
        drain("drain_full");
        read_check("txstat_empty", A_TXSTAT, 32'h0000_0100);

        // Full FIFO: push and pop in the same cycle
        for (int i = 0; i < 8; i++) bus_write(A_TXDATA, 32'(8'hA0 + i));
        tx_ready = 1'b1;
        bus_write(A_TXDATA, 32'h55);
        tx_ready = 1'b0;
        read_check("txstat_push_pop_full", A_TXSTAT, 32'h0000_0208);
        drain("drain_push_pop");

        // Random traffic with random back-pressure
        for (int i = 0; i < 120; i++) begin
            tx_ready = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) != 0) bus_write(A_TXDATA, 32'($urandom_range(0, 255)));
            else step();
        end
        tx_ready = 1'b0;
        drain("drain_random");
        read_check("txstat_random_ovf", A_TXSTAT, model_ovf ? 32'h8000_0100 : 32'h0000_0100);
        bus_write(A_TXSTAT, 32'h0);

        // Reset mid-operation
        bus_write(A_GPIO, 32'h3C);
        for (int i = 0; i < 3; i++) bus_write(A_TXDATA, 32'(8'h70 + i));
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_q.delete();
        model_ovf = 1'b0;
        @(negedge clk);
        check("midrst_tx_valid", 32'(tx_valid), 32'h0);
        check("midrst_tx_data", 32'(tx_data), 32'h0);
        check("midrst_gpio", 32'(gpio_out), 32'h0);
        step();
        read_check("midrst_txstat", A_TXSTAT, 32'h0000_0100);
        tx_ready = 1'b1;
        repeat (4) step();
        @(negedge clk);
        check("midrst_no_valid", 32'(tx_valid), 32'h0);
        step();
        tx_ready = 1'b0;

`ifdef CYCLE_COUNTER_EN
        repeat (100) step();
        snap_exp = live_edges;
        bus_write(A_CYCCTL, 32'h1);
        read_check("cyc_snap_lo", A_CYCLO, 32'(snap_exp));
        read_check("cyc_snap_hi", A_CYCHI, 32'h0);
        l_clr = live_edges;
        bus_write(A_CYCCTL, 32'h3);
        read_check("cyc_snap_then_clear", A_CYCLO, 32'(l_clr));
        snap_exp = live_edges - l_clr - 1;
        bus_write(A_CYCCTL, 32'h1);
        read_check("cyc_after_clear", A_CYCLO, 32'(snap_exp));
        force dut.cyc_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        release dut.cyc_cnt;
        step();
        step();
        bus_write(A_CYCCTL, 32'h1);
        read_check("cyc_wrap_lo", A_CYCLO, 32'h1);
        read_check("cyc_wrap_hi", A_CYCHI, 32'h0);
`else
        repeat (20) step();
        bus_write(A_CYCCTL, 32'h3);
        read_check("nocyc_lo", A_CYCLO, 32'h0);
        read_check("nocyc_hi", A_CYCHI, 32'h0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
